reg_alu_ctrl: RTL and testbench

REG_ALU_CTRL -- requirements
Module: reg_alu_ctrl

---
 rtl/reg_alu_ctrl.sv | 175 +++++++++++++++++
 tb/tb_reg_alu_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_ctrl.sv
// ---------------------------------------------------------------------------
// reg_alu_ctrl
//   Sequencer for a reg_alu datapath. Instructions are queued in a small FIFO
//   and retired one at a time through a three-state FSM:
//   IDLE (pop) -> READ (address regs) -> WRITE (commit). A new instruction
//   can therefore issue every 3 cycles.
//
// Ports
//   clk, reset       : clock (rising edge), asynchronous active-low reset
//   in_valid/ready   : instruction offer handshake, in_ready = (count < DEPTH)
//   in_instr[27:0]   : [27] kind (0=LOAD,1=ALU) [26:25] op [24:22] ra
//                      [21:19] rb [18:16] rd [15:0] imm
//   halt             : blocks new issues (sampled in IDLE only)
//   sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in : datapath controls
//   d_out_a, d_out_b, cout                           : datapath responses
//   busy, done, c_flag, result                       : status
//   count            : FIFO occupancy
// ---------------------------------------------------------------------------
module reg_alu_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [27:0]            in_instr,
    input  logic                   halt,
    output logic                   sel,
    output logic                   wr,
    output logic [1:0]             op,
    output logic [2:0]             rd_addr_a,
    output logic [2:0]             rd_addr_b,
    output logic [2:0]             wr_addr,
    output logic [15:0]            d_in,
    input  logic [15:0]            d_out_a,
    input  logic [15:0]            d_out_b,
    input  logic                   cout,
    output logic                   busy,
    output logic                   done,
    output logic                   c_flag,
    output logic [15:0]            result,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [27:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [27:0]        instr_q;
    logic [15:0]        result_q;
    logic               cFlag_q;
    logic               done_q;
    logic               push, pop;

    // Operand B is only consumed inside the datapath ALU, never by the sequencer.
    logic               unused_d_out_b;
    assign unused_d_out_b = ^d_out_b;

    logic               instrKind;
    logic [1:0]         instrOp;
    logic [2:0]         instrRa, instrRb, instrRd;
    logic [15:0]        instrImm;

    assign instrKind = instr_q[27];
    assign instrOp   = instr_q[26:25];
    assign instrRa   = instr_q[24:22];
    assign instrRb   = instr_q[21:19];
    assign instrRd   = instr_q[18:16];
    assign instrImm  = instr_q[15:0];

    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign count    = count_q;
    assign done     = done_q;
    assign c_flag   = cFlag_q;
    assign result   = result_q;

    // A simultaneous push and pop cancel out; full blocks the push via in_ready
    // and empty blocks the pop in the FSM, so the count never over/underflows.
    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Next-state and datapath drive. Everything idles at zero so the datapath
    // sees a quiet bus whenever no instruction is in flight.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        sel       = 1'b0;
        wr        = 1'b0;
        op        = 2'b00;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        wr_addr   = 3'd0;
        d_in      = 16'h0000;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((count_q != '0) && !halt) begin
                    pop     = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                rd_addr_a = instrRa;
                rd_addr_b = instrRb;
                state_d   = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                wr        = 1'b1;
                sel       = instrKind;
                op        = instrOp;
                rd_addr_a = instrRa;
                rd_addr_b = instrRb;
                wr_addr   = instrRd;
                d_in      = instrKind ? 16'h0000 : instrImm;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage carries no reset: validity is tracked purely by the
    // pointers and count, so clearing those discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= in_instr;
        end
    end

    // Control state. Pointers wrap naturally because DEPTH is a power of 2.
    // result/c_flag are captured at the WRITE exit edge, when d_out_a and cout
    // still reflect the operands of the instruction being committed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            instr_q  <= '0;
            result_q <= 16'h0000;
            cFlag_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= (state_q == WRITE);
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
                instr_q <= mem_q[rdPtr_q];
            end
            if (state_q == WRITE) begin
                result_q <= d_out_a;
                if (instrKind) begin
                    cFlag_q <= cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_alu_ctrl
//   Self-checking bench for reg_alu_ctrl. A behavioural 8x16 register file
//   with a small ALU stands in for the reg_alu datapath. Every accepted
//   instruction is pushed onto a scoreboard queue; a negedge monitor pops it
//   when wr appears and checks the write fields, then checks the following
//   done/result/c_flag commit.
// ---------------------------------------------------------------------------
module tb_reg_alu_ctrl;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [27:0]            in_instr;
    logic                   halt;
    logic                   sel, wr;
    logic [1:0]             op;
    logic [2:0]             rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0]            d_in;
    logic [15:0]            d_out_a, d_out_b;
    logic                   cout;
    logic                   busy, done, c_flag;
    logic [15:0]            result;
    logic [$clog2(DEPTH):0] count;

    int nCompared   = 0;
    int nMismatched = 0;
    int cycleCnt    = 0;
    int writesSeen  = 0;
    int donesSeen   = 0;

    logic [27:0] sbQ [$];
    int          wrCycles [$];
    logic        donePending = 1'b0;
    logic [15:0] expResult   = 16'h0000;
    logic        expCflag    = 1'b0;
    logic        prevWr      = 1'b0;
    logic [27:0] cur;
    logic [15:0] expDin;

    logic [15:0] regs [8] = '{default: 16'h0000};

    reg_alu_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .halt      (halt),
        .sel       (sel),
        .wr        (wr),
        .op        (op),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b),
        .cout      (cout),
        .busy      (busy),
        .done      (done),
        .c_flag    (c_flag),
        .result    (result),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic carryOf(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (f)
            2'b00:   return s[16];
            2'b01:   return (a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] aluOf(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [27:0] mkInstr(input logic kind, input logic [1:0] f, input logic [2:0] ra,
                                            input logic [2:0] rb, input logic [2:0] rd, input logic [15:0] imm);
        return {kind, f, ra, rb, rd, imm};
    endfunction

    // Behavioural reg_alu datapath: asynchronous reads, write on wr.
    assign d_out_a = regs[rd_addr_a];
    assign d_out_b = regs[rd_addr_b];
    assign cout    = carryOf(op, d_out_a, d_out_b);

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (wr === 1'b1) begin
            regs[wr_addr] <= sel ? aluOf(op, d_out_a, d_out_b) : d_in;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            nCompared++;
            if (donePending) begin
                if (done !== 1'b1 || result !== expResult || c_flag !== expCflag) begin
                    nMismatched++;
                    $display("[TB] FAIL commit: done=%b result=%h c_flag=%b, required done=1 result=%h c_flag=%b",
                             done, result, c_flag, expResult, expCflag);
                end
                if (done === 1'b1) donesSeen++;
                donePending = 1'b0;
            end else if (done !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL spurious_done: done=%b, required 0", done);
            end
            if (wr === 1'b1) begin
                nCompared++;
                if (prevWr) begin
                    nMismatched++;
                    $display("[TB] FAIL wr_width: wr high 2 cycles, required 1");
                end
                nCompared++;
                if (sbQ.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL unexpected_wr: wr=1 wr_addr=%0d, required no write", wr_addr);
                end else begin
                    cur    = sbQ.pop_front();
                    expDin = cur[27] ? 16'h0000 : cur[15:0];
                    if ({sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in, busy} !==
                        {cur[27], cur[26:25], cur[24:22], cur[21:19], cur[18:16], expDin, 1'b1}) begin
                        nMismatched++;
                        $display("[TB] FAIL write_fields: sel=%b op=%b ra=%0d rb=%0d wa=%0d d_in=%h busy=%b, required sel=%b op=%b ra=%0d rb=%0d wa=%0d d_in=%h busy=1",
                                 sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in, busy,
                                 cur[27], cur[26:25], cur[24:22], cur[21:19], cur[18:16], expDin);
                    end
                    expResult = regs[cur[24:22]];
                    if (cur[27]) expCflag = carryOf(cur[26:25], regs[cur[24:22]], regs[cur[21:19]]);
                    donePending = 1'b1;
                    writesSeen++;
                    wrCycles.push_back(cycleCnt);
                end
            end else if (busy === 1'b0) begin
                nCompared++;
                if ({sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in} !== 31'h0) begin
                    nMismatched++;
                    $display("[TB] FAIL idle_outputs: sel=%b wr=%b op=%b ra=%0d rb=%0d wa=%0d d_in=%h, required all 0",
                             sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in);
                end
            end
            prevWr = (wr === 1'b1);
        end else begin
            prevWr = 1'b0;
        end
    end

    // Offer one instruction for one clock edge; accepted reflects in_ready.
    task automatic applyStimulus(input logic [27:0] instr, output bit accepted);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        accepted = (in_ready === 1'b1);
        if (accepted) sbQ.push_back(instr);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        bit finished = 1'b0;
        for (int i = 0; i < 300 && !finished; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && busy === 1'b0 && !donePending && count === '0) finished = 1'b1;
        end
        @(negedge clk);
        nCompared++;
        if (!finished) begin
            nMismatched++;
            $display("[TB] FAIL %s_drain: %0d instructions still pending after 300 cycles, required 0", tag, sbQ.size());
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        halt     = 1'b0;
        repeat (2) @(negedge clk);
        nCompared++;
        if ({sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in} !== 31'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_datapath: bus=%h, required 0", {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in});
        end
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || c_flag !== 1'b0 || result !== 16'h0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_status: busy=%b done=%b c_flag=%b result=%h, required 0 0 0 0000", busy, done, c_flag, result);
        end
        nCompared++;
        if (count !== '0 || in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_fifo: count=%0d in_ready=%b, required 0 1", count, in_ready);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load();
        bit acc;
        int w0 = writesSeen;
        int d0 = donesSeen;
        wrCycles.delete();
        applyStimulus(mkInstr(1'b0, 2'b00, 3'd0, 3'd0, 3'd3, 16'hcdef), acc);
        applyStimulus(mkInstr(1'b0, 2'b00, 3'd0, 3'd0, 3'd7, 16'h3210), acc);
        waitDrain("load");
        nCompared++;
        if (writesSeen - w0 !== 2 || donesSeen - d0 !== 2) begin
            nMismatched++;
            $display("[TB] FAIL load_counts: writes=%0d dones=%0d, required 2 2", writesSeen - w0, donesSeen - d0);
        end
        nCompared++;
        if (wrCycles.size() != 2 || wrCycles[1] - wrCycles[0] != 3) begin
            nMismatched++;
            $display("[TB] FAIL load_spacing: %0d wr pulses, required 2 pulses 3 cycles apart", wrCycles.size());
        end
        nCompared++;
        if (regs[3] !== 16'hcdef || regs[7] !== 16'h3210) begin
            nMismatched++;
            $display("[TB] FAIL load_regs: R3=%h R7=%h, required cdef 3210", regs[3], regs[7]);
        end
    endtask

    task automatic test_alu();
        bit acc;
        applyStimulus(mkInstr(1'b0, 2'b00, 3'd0, 3'd0, 3'd1, 16'hba98), acc);
        applyStimulus(mkInstr(1'b0, 2'b00, 3'd0, 3'd0, 3'd5, 16'h4567), acc);
        applyStimulus(mkInstr(1'b1, 2'b00, 3'd1, 3'd5, 3'd2, 16'h1234), acc);
        waitDrain("alu_add");
        nCompared++;
        if (regs[2] !== 16'hffff || c_flag !== 1'b0 || result !== 16'hba98) begin
            nMismatched++;
            $display("[TB] FAIL alu_nocarry: R2=%h c_flag=%b result=%h, required ffff 0 ba98", regs[2], c_flag, result);
        end
        applyStimulus(mkInstr(1'b1, 2'b00, 3'd1, 3'd1, 3'd3, 16'h0000), acc);
        waitDrain("alu_carry");
        nCompared++;
        if (regs[3] !== 16'h7530 || c_flag !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL alu_carry: R3=%h c_flag=%b, required 7530 1", regs[3], c_flag);
        end
        applyStimulus(mkInstr(1'b0, 2'b00, 3'd5, 3'd0, 3'd6, 16'h0001), acc);
        waitDrain("load_keeps_flag");
        nCompared++;
        if (c_flag !== 1'b1 || result !== 16'h4567 || regs[6] !== 16'h0001) begin
            nMismatched++;
            $display("[TB] FAIL load_keeps_flag: c_flag=%b result=%h R6=%h, required 1 4567 0001", c_flag, result, regs[6]);
        end
    endtask

    task automatic test_halt_full();
        bit acc;
        int w0 = writesSeen;
        @(negedge clk);
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mkInstr(1'b0, 2'b00, 3'(i), 3'd0, 3'(i + 1), 16'h1000 + 16'(i)), acc);
            nCompared++;
            if (acc !== (i < 4)) begin
                nMismatched++;
                $display("[TB] FAIL halt_accept_%0d: accepted=%b, required %b", i, acc, (i < 4));
            end
        end
        repeat (3) @(negedge clk);
        nCompared++;
        if (count !== 3'd4 || in_ready !== 1'b0 || writesSeen !== w0 || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL halt_full: count=%0d in_ready=%b writes=%0d busy=%b, required 4 0 0 0",
                     count, in_ready, writesSeen - w0, busy);
        end
        halt = 1'b0;
        waitDrain("halt_full");
        nCompared++;
        if (writesSeen - w0 !== 4) begin
            nMismatched++;
            $display("[TB] FAIL halt_release_writes: writes=%0d, required 4", writesSeen - w0);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int w0 = writesSeen;
        int tries;
        @(negedge clk);
        halt = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(28'($urandom), acc);
        @(negedge clk);
        halt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 10) begin
                applyStimulus(28'($urandom), acc);
                tries++;
                nCompared++;
                if (count > 3'd4) begin
                    nMismatched++;
                    $display("[TB] FAIL b2b_count: count=%0d, required <= 4", count);
                end
            end
            nCompared++;
            if (!acc) begin
                nMismatched++;
                $display("[TB] FAIL b2b_accept: instruction %0d not accepted in 10 offers, required accepted", i);
            end
        end
        waitDrain("b2b");
        nCompared++;
        if (writesSeen - w0 !== 16) begin
            nMismatched++;
            $display("[TB] FAIL b2b_writes: writes=%0d, required 16", writesSeen - w0);
        end
    endtask

    task automatic test_halt_read();
        bit acc;
        int w0 = writesSeen;
        applyStimulus(mkInstr(1'b0, 2'b00, 3'd0, 3'd0, 3'd1, 16'h1111), acc);
        applyStimulus(mkInstr(1'b0, 2'b00, 3'd0, 3'd0, 3'd2, 16'h2222), acc);
        @(negedge clk);
        nCompared++;
        if (busy !== 1'b1 || wr !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL halt_read_state: busy=%b wr=%b, required 1 0", busy, wr);
        end
        halt = 1'b1;
        repeat (8) @(negedge clk);
        nCompared++;
        if (writesSeen - w0 !== 1 || busy !== 1'b0 || count !== 3'd1 || regs[1] !== 16'h1111) begin
            nMismatched++;
            $display("[TB] FAIL halt_read_hold: writes=%0d busy=%b count=%0d R1=%h, required 1 0 1 1111",
                     writesSeen - w0, busy, count, regs[1]);
        end
        halt = 1'b0;
        waitDrain("halt_read");
        nCompared++;
        if (writesSeen - w0 !== 2 || regs[2] !== 16'h2222) begin
            nMismatched++;
            $display("[TB] FAIL halt_read_release: writes=%0d R2=%h, required 2 2222", writesSeen - w0, regs[2]);
        end
    endtask

    task automatic test_reset_abort();
        bit acc;
        int w0 = writesSeen;
        logic [15:0] r4 = regs[4];
        applyStimulus(mkInstr(1'b0, 2'b00, 3'd0, 3'd0, 3'd4, 16'h4444), acc);
        applyStimulus(mkInstr(1'b0, 2'b00, 3'd0, 3'd0, 3'd6, 16'h6666), acc);
        @(negedge clk);
        nCompared++;
        if (busy !== 1'b1 || wr !== 1'b0 || rd_addr_a !== 3'd0 || count !== 3'd1) begin
            nMismatched++;
            $display("[TB] FAIL abort_read_state: busy=%b wr=%b count=%0d, required 1 0 1", busy, wr, count);
        end
        reset = 1'b0;
        sbQ.delete();
        donePending = 1'b0;
        expCflag    = 1'b0;
        #1;
        nCompared++;
        if ({sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in} !== 31'h0 || busy !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL abort_outputs: bus=%h busy=%b done=%b, required 0 0 0",
                     {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in}, busy, done);
        end
        nCompared++;
        if (count !== '0 || c_flag !== 1'b0 || result !== 16'h0000) begin
            nMismatched++;
            $display("[TB] FAIL abort_state: count=%0d c_flag=%b result=%h, required 0 0 0000", count, c_flag, result);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        nCompared++;
        if (writesSeen !== w0 || regs[4] !== r4 || count !== '0 || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL abort_after: writes=%0d R4=%h count=%0d busy=%b, required 0 %h 0 0",
                     writesSeen - w0, regs[4], count, busy, r4);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_alu();
        test_halt_full();
        test_back_to_back();
        test_halt_read();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
